rr_arb4_idx: RTL and testbench

- Four-requester round-robin arbiter that produces a registered 2-bit grant index plus a grant-valid strobe.
- Sits directly upstream of the 2:4 decoder (dec2x4):
  - `gnt_idx[1]` drives decoder input `a`.
  - `gnt_idx[0]` drives decoder input `b`.
  - `gnt_vld` drives decoder enable `e`.
  - The decoder output is therefore the one-hot grant vector.
- A grant is held until the holder releases it, drops its request, or hits the hold limit. Rotation then continues from the next requester.

---
 rtl/rr_arb4_idx.sv | 124 ++++++++++++
 tb/tb_rr_arb4_idx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_idx.sv
// rr_arb4_idx: four-requester round-robin arbiter with a registered 2-bit
// grant index, grant-valid strobe and hold counter. Downstream, gnt_idx and
// gnt_vld drive a 2:4 decoder that produces the one-hot grant vector.
// A grant ends on rel, on the holder dropping its request, or on reaching
// MAX_HOLD. The next winner is then chosen on the same edge, with no idle
// bubble between grants.
module rr_arb4_idx #(
  parameter int unsigned MAX_HOLD = 8  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic [7:0] hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       end_evt_s;

  // Round-robin pick: scan last+1 .. last+4 (mod 4). The first requester
  // found wins, so 'last' itself has the lowest priority but stays eligible.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    pick  = l;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = l + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
  endfunction

  // End of the current grant: release, holder dropped its request, or hold limit reached.
  always_comb begin
    end_evt_s = rel || !req[gnt_idx_q] || (hold_cnt_q == MAX_HOLD_C);
  end

  // Next-state and output computation for the two-state arbiter.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          gnt_idx_d  = pick(req, last_q);
          gnt_vld_d  = 1'b1;
          hold_cnt_d = 8'd1;
          state_d    = GRANT;
        end else begin
          gnt_vld_d  = 1'b0;
          hold_cnt_d = 8'd0;
          state_d    = IDLE;
        end
      end
      GRANT: begin
        if (!end_evt_s) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          last_d = gnt_idx_q;
          if (req != 4'b0000) begin
            // Back-to-back handover; may re-grant the holder if it is the sole requester.
            gnt_idx_d  = pick(req, gnt_idx_q);
            gnt_vld_d  = 1'b1;
            hold_cnt_d = 8'd1;
            state_d    = GRANT;
          end else begin
            // gnt_idx keeps the last holder's index while idle.
            gnt_vld_d  = 1'b0;
            hold_cnt_d = 8'd0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_vld_d  = 1'b0;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 2'd3;
      gnt_idx_q  <= 2'd0;
      gnt_vld_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_idx  = gnt_idx_q;
  assign gnt_vld  = gnt_vld_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_rr_arb4_idx.sv
// Directed testbench for rr_arb4_idx. Two instances share the same stimulus:
// one with MAX_HOLD=8 and one with MAX_HOLD=4. Expected values are
// hand-computed constants.
module tb_rr_arb4_idx;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [1:0] idx8, idx4;
  logic       vld8, vld4;
  logic [7:0] cnt8, cnt4;

  int n_cmp;
  int n_err;

  rr_arb4_idx #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt_idx(idx8), .gnt_vld(vld8), .hold_cnt(cnt8)
  );

  rr_arb4_idx #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt_idx(idx4), .gnt_vld(vld4), .hold_cnt(cnt4)
  );

  // Clock generation: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges with all inputs quiet.
  task automatic do_reset();
    req = 4'b0000;
    rel = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Observed decoder output, derived from the arbiter outputs.
  function automatic logic [3:0] dec(input logic v, input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return v ? (one << i) : 4'b0000;
  endfunction

  initial begin
    logic [1:0] e_idx8 [9];
    logic [7:0] e_cnt8 [9];
    logic [1:0] e_idx4 [9];
    logic [7:0] e_cnt4 [9];
    logic [1:0] e_rot  [6];

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req = 4'b0000;
    rel = 1'b0;
    #3;
    check("rst_vld", {7'd0, vld8}, 8'd0);
    check("rst_idx", {6'd0, idx8}, 8'd0);
    check("rst_cnt", cnt8, 8'd0);
    step();
    rst = 1'b0;

    // Test 1: single request from requester 2.
    req = 4'b0100;
    step();
    check("t1_idx", {6'd0, idx8}, 8'd2);
    check("t1_vld", {7'd0, vld8}, 8'd1);
    check("t1_cnt", cnt8, 8'd1);
    check("t1_dec", {4'd0, dec(vld8, idx8)}, 8'b0000_0100);
    step();
    check("t1_cnt2", cnt8, 8'd2);

    // Test 2: all request, rel every cycle -> strict rotation.
    do_reset();
    req = 4'b1111;
    rel = 1'b1;
    e_rot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t2_idx%0d", k), {6'd0, idx8}, {6'd0, e_rot[k]});
      check($sformatf("t2_vld%0d", k), {7'd0, vld8}, 8'd1);
      check($sformatf("t2_cnt%0d", k), cnt8, 8'd1);
    end

    // Test 3: req=0011, no rel; hold-limit rotation for both instances.
    do_reset();
    req = 4'b0011;
    e_idx4 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    e_cnt4 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
    e_idx8 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    e_cnt8 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd1};
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("t3_idx4_%0d", k), {6'd0, idx4}, {6'd0, e_idx4[k]});
      check($sformatf("t3_cnt4_%0d", k), cnt4, e_cnt4[k]);
      check($sformatf("t3_vld4_%0d", k), {7'd0, vld4}, 8'd1);
      check($sformatf("t3_idx8_%0d", k), {6'd0, idx8}, {6'd0, e_idx8[k]});
      check($sformatf("t3_cnt8_%0d", k), cnt8, e_cnt8[k]);
    end

    // Test 4: sole requester 0 re-granted after each timeout, no bubble.
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("t4_idx_%0d", k), {6'd0, idx4}, 8'd0);
      check($sformatf("t4_vld_%0d", k), {7'd0, vld4}, 8'd1);
      check($sformatf("t4_cnt_%0d", k), cnt4, e_cnt4[k]);
    end

    // Test 5: requester 1 holds, then all requests drop; rel in idle ignored.
    do_reset();
    req = 4'b0010;
    step();
    check("t5_idx_a", {6'd0, idx8}, 8'd1);
    step();
    check("t5_cnt_b", cnt8, 8'd2);
    req = 4'b0000;
    step();
    check("t5_vld_drop", {7'd0, vld8}, 8'd0);
    check("t5_cnt_drop", cnt8, 8'd0);
    check("t5_idx_drop", {6'd0, idx8}, 8'd1);
    rel = 1'b1;
    step();
    check("t5_vld_rel", {7'd0, vld8}, 8'd0);
    check("t5_cnt_rel", cnt8, 8'd0);
    check("t5_idx_rel", {6'd0, idx8}, 8'd1);
    rel = 1'b0;

    // Test 6: asynchronous reset mid-grant, then grant to requester 3.
    do_reset();
    req = 4'b1000;
    step();
    step();
    check("t6_idx_pre", {6'd0, idx8}, 8'd3);
    check("t6_cnt_pre", cnt8, 8'd2);
    #3;
    rst = 1'b1;
    #1;
    check("t6_vld_rst", {7'd0, vld8}, 8'd0);
    check("t6_idx_rst", {6'd0, idx8}, 8'd0);
    check("t6_cnt_rst", cnt8, 8'd0);
    rst = 1'b0;
    step();
    check("t6_idx_post", {6'd0, idx8}, 8'd3);
    check("t6_vld_post", {7'd0, vld8}, 8'd1);
    check("t6_cnt_post", cnt8, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
